// File: rtl/enc_dec_pkg.sv
// Shared SEC-DED code definitions for the Hamming codec (encoder and decoder).
// Holds the width encoding, the per-width code geometry and the column map
// of each data bit in the check matrix.
package enc_dec_pkg;

  typedef enum logic [1:0] {
    W8  = 2'b00,
    W16 = 2'b01,
    W32 = 2'b10
  } width_e;

  localparam int D8  = 4;
  localparam int D16 = 11;
  localparam int D32 = 26;
  localparam int M8  = 3;
  localparam int M16 = 4;
  localparam int M32 = 5;
  localparam int P8  = M8 + 1;
  localparam int P16 = M16 + 1;
  localparam int P32 = M32 + 1;

  // Number of Hamming (non-overall) check bits for a width.
  function automatic int m_of(width_e w);
    case (w)
      W8:      return M8;
      W16:     return M16;
      default: return M32;
    endcase
  endfunction

  // Number of data bits carried for a width.
  function automatic int d_of(width_e w);
    case (w)
      W8:      return D8;
      W16:     return D16;
      default: return D32;
    endcase
  endfunction

  // Total codeword length in bits for a width.
  function automatic int w_bits_of(width_e w);
    case (w)
      W8:      return 8;
      W16:     return 16;
      default: return 32;
    endcase
  endfunction

  // Column of data bit j: the j-th smallest m-bit value of weight >= 2.
  function automatic logic [4:0] col_of(width_e w, int j);
    logic [4:0] res;
    int         cnt;
    int         m;
    res = 5'd0;
    cnt = 0;
    m   = m_of(w);
    for (int v = 3; v < 32; v++) begin
      if ((v < (1 << m)) && ($countones(5'(v)) >= 2)) begin
        if (cnt == j) begin
          res = 5'(v);
        end
        cnt++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/enc_parity_gen.sv
// Combinational extended-Hamming codeword builder. Data bits sit above the
// check bits, Hamming checks in [m-1:0], overall parity in bit m.
module enc_parity_gen
  import enc_dec_pkg::*;
(
  input  logic [25:0] i_data,
  input  width_e      i_width,
  output logic [31:0] o_codeword
);

  // Builds the codeword for one fixed width; called with constant widths only.
  function automatic logic [31:0] build_cw(logic [25:0] d, width_e w);
    logic [31:0] cw;
    logic [4:0]  col;
    int          m;
    m  = m_of(w);
    cw = 32'd0;
    for (int j = 0; j < 26; j++) begin
      if (j < d_of(w)) begin
        cw[5'(m + 1 + j)] = d[5'(j)];
        col = col_of(w, j);
        for (int k = 0; k < 5; k++) begin
          if ((k < m) && col[3'(k)]) begin
            cw[5'(k)] = cw[5'(k)] ^ d[5'(j)];
          end
        end
      end
    end
    // bit m is still zero here, so the reduction gives even total weight
    cw[5'(m)] = ^cw;
    return cw;
  endfunction

  // Select the codeword of the width travelling with this word.
  always_comb begin
    o_codeword = 32'd0;
    case (i_width)
      W8:      o_codeword = build_cw(i_data, W8);
      W16:     o_codeword = build_cw(i_data, W16);
      default: o_codeword = build_cw(i_data, W32);
    endcase
  end

endmodule

// File: rtl/enc_codeword_pipe.sv
// Two-stage pipelined SEC-DED encoder with valid/ready handshake.
// s1 registers masked data and normalised width; s2 registers the codeword.
// Optional feature macro: ENC_ERR_INJECT_EN (adds single-bit error injection).
module enc_codeword_pipe
  import enc_dec_pkg::*;
#(
  parameter int PIPE_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [25:0] data_in,
  input  logic [1:0]  codeword_width,
`ifdef ENC_ERR_INJECT_EN
  input  logic        err_inject,
  input  logic [4:0]  err_inject_pos,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] codeword_out,
  output logic [1:0]  width_out
);

  generate
    if (PIPE_STAGES != 2) begin : g_bad_stages
      $error("enc_codeword_pipe: PIPE_STAGES must be 2");
    end
  endgenerate

  logic        r_s1_valid;
  logic [25:0] r_s1_data;
  width_e      r_s1_width;
  logic        r_out_valid;
  logic [31:0] r_codeword;
  logic [1:0]  r_width_out;

  width_e      w_width_n;
  logic [25:0] w_mask;
  logic        w_s2_adv;
  logic        w_s1_adv;
  logic [31:0] w_cw_clean;
  logic [31:0] w_cw_final;

`ifdef ENC_ERR_INJECT_EN
  logic        r_s1_inj;
  logic [4:0]  r_s1_pos;
`endif

  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  // Normalise the width select (bit1 wins) and derive the data mask.
  always_comb begin
    w_width_n = W8;
    w_mask    = 26'h000000F;
    if (codeword_width[1]) begin
      w_width_n = W32;
      w_mask    = 26'h3FFFFFF;
    end else if (codeword_width[0]) begin
      w_width_n = W16;
      w_mask    = 26'h00007FF;
    end else begin
      w_width_n = W8;
      w_mask    = 26'h000000F;
    end
  end

  // Stage 1: capture the accepted word; drop the valid flag on idle advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= 26'd0;
      r_s1_width <= W8;
`ifdef ENC_ERR_INJECT_EN
      r_s1_inj   <= 1'b0;
      r_s1_pos   <= 5'd0;
`endif
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data  <= data_in & w_mask;
        r_s1_width <= w_width_n;
`ifdef ENC_ERR_INJECT_EN
        r_s1_inj   <= err_inject;
        r_s1_pos   <= err_inject_pos;
`endif
      end
    end
  end

  enc_parity_gen u_parity_gen (
    .i_data     (r_s1_data),
    .i_width    (r_s1_width),
    .o_codeword (w_cw_clean)
  );

  // Optional single-bit corruption of the clean codeword inside the word.
  always_comb begin
    w_cw_final = w_cw_clean;
`ifdef ENC_ERR_INJECT_EN
    if (r_s1_inj && ({27'd0, r_s1_pos} < 32'(w_bits_of(r_s1_width)))) begin
      w_cw_final[r_s1_pos] = ~w_cw_clean[r_s1_pos];
    end else begin
      w_cw_final = w_cw_clean;
    end
`endif
  end

  // Stage 2: output register; holds its word until the sink takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_codeword  <= 32'd0;
      r_width_out <= 2'b00;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_codeword  <= w_cw_final;
        r_width_out <= r_s1_width;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign codeword_out = r_codeword;
  assign width_out    = r_width_out;

endmodule

// File: tb/tb_enc_codeword_pipe.sv
// Directed self-checking bench for enc_codeword_pipe. Expected codewords are
// hand-computed from the code definition. Error-injection vectors run only
// when ENC_ERR_INJECT_EN is defined.
module tb_enc_codeword_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [25:0] data_in;
  logic [1:0]  codeword_width;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] codeword_out;
  logic [1:0]  width_out;
`ifdef ENC_ERR_INJECT_EN
  logic        err_inject;
  logic [4:0]  err_inject_pos;
`endif

  int n_checks;
  int n_errors;

  enc_codeword_pipe #(.PIPE_STAGES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .data_in        (data_in),
    .codeword_width (codeword_width),
`ifdef ENC_ERR_INJECT_EN
    .err_inject     (err_inject),
    .err_inject_pos (err_inject_pos),
`endif
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .codeword_out   (codeword_out),
    .width_out      (width_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Single word with out_ready high: accept, 1 cycle in s1, then out_valid.
  task automatic send_one(input string tag, input logic [1:0] w, input logic [25:0] d,
                          input logic inj, input logic [4:0] pos,
                          input logic [31:0] exp_cw, input logic [1:0] exp_w);
    @(negedge clk);
    in_valid       = 1'b1;
    data_in        = d;
    codeword_width = w;
    out_ready      = 1'b1;
`ifdef ENC_ERR_INJECT_EN
    err_inject     = inj;
    err_inject_pos = pos;
`endif
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    data_in  = 26'd0;
    #1;
    chk({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_cw"}, codeword_out, exp_cw);
    chk({tag, "_w"}, 32'(width_out), 32'(exp_w));
    @(negedge clk);
    #1;
    chk({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  logic [25:0] mv_data [8];
  logic [1:0]  mv_w    [8];
  logic [31:0] mv_cw   [8];
  logic [1:0]  mv_wo   [8];

  initial begin
    int          sent;
    int          got;
    logic        held;
    logic [31:0] held_cw;
    logic [1:0]  held_w;

    n_checks = 0;
    n_errors = 0;
    rst            = 1'b1;
    in_valid       = 1'b0;
    data_in        = 26'd0;
    codeword_width = 2'b00;
    out_ready      = 1'b0;
`ifdef ENC_ERR_INJECT_EN
    err_inject     = 1'b0;
    err_inject_pos = 5'd0;
`endif

    // mixed-width stream; word 0 has unused high bits set, word 4 uses 2'b11
    mv_data[0] = 26'h3FFFFF1; mv_w[0] = 2'b00; mv_cw[0] = 32'h0000001B; mv_wo[0] = 2'b00;
    mv_data[1] = 26'h0000000; mv_w[1] = 2'b01; mv_cw[1] = 32'h00000000; mv_wo[1] = 2'b01;
    mv_data[2] = 26'h000000F; mv_w[2] = 2'b00; mv_cw[2] = 32'h000000FF; mv_wo[2] = 2'b00;
    mv_data[3] = 26'h0000001; mv_w[3] = 2'b01; mv_cw[3] = 32'h00000033; mv_wo[3] = 2'b01;
    mv_data[4] = 26'h0000001; mv_w[4] = 2'b11; mv_cw[4] = 32'h00000063; mv_wo[4] = 2'b10;
    mv_data[5] = 26'h0000002; mv_w[5] = 2'b00; mv_cw[5] = 32'h0000002D; mv_wo[5] = 2'b00;
    mv_data[6] = 26'h0000002; mv_w[6] = 2'b01; mv_cw[6] = 32'h00000055; mv_wo[6] = 2'b01;
    mv_data[7] = 26'h0000002; mv_w[7] = 2'b10; mv_cw[7] = 32'h000000A5; mv_wo[7] = 2'b10;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_cw", codeword_out, 32'd0);
    chk("rst_w", 32'(width_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // directed single words
    send_one("w8_1",   2'b00, 26'h0000001, 1'b0, 5'd0, 32'h0000001B, 2'b00);
    send_one("w8_f",   2'b00, 26'h000000F, 1'b0, 5'd0, 32'h000000FF, 2'b00);
    send_one("w16_1",  2'b01, 26'h0000001, 1'b0, 5'd0, 32'h00000033, 2'b01);
    send_one("w32_1",  2'b10, 26'h0000001, 1'b0, 5'd0, 32'h00000063, 2'b10);
    send_one("w16_0",  2'b01, 26'h0000000, 1'b0, 5'd0, 32'h00000000, 2'b01);
`ifdef ENC_ERR_INJECT_EN
    send_one("inj_p2", 2'b00, 26'h0000001, 1'b1, 5'd2, 32'h0000001F, 2'b00);
    send_one("inj_p9", 2'b00, 26'h0000001, 1'b1, 5'd9, 32'h0000001B, 2'b00);
    send_one("inj_p31_w32", 2'b10, 26'h0000001, 1'b1, 5'd31, 32'h80000063, 2'b10);
    err_inject = 1'b0;
`endif

    // back-to-back stream under random backpressure
    sent = 0;
    got  = 0;
    held = 1'b0;
    held_cw = 32'd0;
    held_w  = 2'b00;
    for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 8);
      if (sent < 8) begin
        data_in        = mv_data[sent];
        codeword_width = mv_w[sent];
      end
      #1;
      if (held) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_cw", codeword_out, held_cw);
        chk("stall_w", 32'(width_out), 32'(held_w));
      end
      if (out_valid && out_ready) begin
        chk($sformatf("stream_cw%0d", got), codeword_out, mv_cw[got]);
        chk($sformatf("stream_w%0d", got), 32'(width_out), 32'(mv_wo[got]));
        chk($sformatf("stream_par%0d", got), 32'(^codeword_out), 32'd0);
        got++;
      end
      held    = out_valid && !out_ready;
      held_cw = codeword_out;
      held_w  = width_out;
      if (in_valid && in_ready) sent++;
    end
    chk("stream_count", 32'(got), 32'd8);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("stream_no_extra", 32'(out_valid), 32'd0);
    end

    // fill the pipe, then reset mid-transfer
    @(negedge clk);
    out_ready      = 1'b0;
    in_valid       = 1'b1;
    data_in        = 26'h000000F;
    codeword_width = 2'b00;
    @(negedge clk);
    data_in        = 26'h0000001;
    codeword_width = 2'b01;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("after_rst_in_ready", 32'(in_ready), 32'd1);
    chk("after_rst_cw", codeword_out, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("after_rst_no_old", 32'(out_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
